fifo_rd_drain: RTL and testbench

Read-side drain engine that sits directly downstream of the synchronous FIFO (`syn_fifo`). It pops words through the FIFO read port (`rd_cs`/`rd_en`), absorbs the FIFO's one-cycle read latency, and presents the data as a valid/ready stream. A 2-entry skid buffer lets the stream sustain one word per cycle under back-pressure. The block also marks fixed-length bursts with `out_last` and keeps a running delivered-word count.

---
 rtl/fifo_rd_drain.sv | 102 ++++++++++
 tb/tb_fifo_rd_drain.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-side drain engine for syn_fifo. It pops words through the FIFO read
// port, absorbs the one-cycle FIFO read latency, and presents the words as a
// valid/ready stream through a 2-entry skid buffer. It also marks fixed-length
// bursts with out_last and counts the words handed off.
//
// Ports:
//   clk         system clock, rising edge (same clock as the FIFO)
//   rst         asynchronous reset, active-low
//   enable      1 = issue FIFO reads; 0 = only drain words already fetched
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after a read is issued
//   fifo_rd_cs  FIFO read chip select (equal to fifo_rd_en)
//   fifo_rd_en  FIFO read enable, one word popped per cycle high
//   out_data    stream data (skid entry 0)
//   out_valid   stream word valid
//   out_ready   downstream accepts the word
//   out_last    current word is beat BURST_LEN-1 of its burst
//   word_count  words handed off since reset, wraps
module fifo_rd_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  logic                  inflight;
  logic [1:0]            occ;
  logic [1:0]            occ_n;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [DATA_WIDTH-1:0] buf0_n;
  logic [DATA_WIDTH-1:0] buf1_n;
  logic [15:0]           beat;
  logic                  pop;
  logic [1:0]            slot;
  logic [2:0]            pend;

  assign out_valid  = (occ != 2'd0);
  assign out_data   = buf0;
  assign out_last   = out_valid & (beat == LAST_BEAT);
  assign fifo_rd_cs = fifo_rd_en;

  always_comb begin
    pop    = out_valid & out_ready;
    // Occupancy after this edge if no new read is issued; a read is allowed
    // only while that leaves room for the word it will return.
    pend   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    // Gated by rst so the read port stays quiet while reset is held.
    fifo_rd_en = rst & enable & ~fifo_empty & (pend < 3'd2);
    slot   = occ - {1'b0, pop};
    occ_n  = pend[1:0];
    buf0_n = buf0;
    buf1_n = buf1;
    if (pop) begin
      buf0_n = buf1;
    end
    // Capture lands behind whatever survives the pop, preserving FIFO order.
    if (inflight) begin
      if (slot == 2'd0) begin
        buf0_n = fifo_data;
      end else begin
        buf1_n = fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= 1'b0;
      occ        <= '0;
      buf0       <= '0;
      buf1       <= '0;
      beat       <= '0;
      word_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_n;
      buf0     <= buf0_n;
      buf1     <= buf1_n;
      if (pop) begin
        beat       <= (beat == LAST_BEAT) ? '0 : beat + 16'd1;
        word_count <= word_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: a behavioural FIFO feeds the DUT,
// every written word is pushed to a scoreboard with its expected out_last,
// and handed-off words are popped and compared.
module tb_fifo_rd_drain;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = '0;
  logic        fifo_rd_cs;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  logic [8:0] exp_q[$];
  int wpos = 0;

  int cyc = 0;
  int m_occ = 0;
  int m_infl = 0;
  int m_wc = 0;
  int rd_pulses = 0;
  int first_rd = -1;
  int first_val = -1;
  int last_pop = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  fifo_rd_drain #(.DATA_WIDTH(8), .BURST_LEN(BL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    fq.push_back(d);
    exp_q.push_back({((wpos % BL) == BL - 1) ? 1'b1 : 1'b0, d});
    wpos++;
    fifo_empty <= 1'b0;
  endtask

  // FIFO shares the DUT reset: contents and expectations are discarded.
  always @(negedge rst) begin
    fq.delete();
    exp_q.delete();
    wpos = 0;
    fifo_empty <= 1'b1;
  end

  // Synchronous-read FIFO model: data appears the cycle after the read.
  always @(posedge clk) begin
    if (rst === 1'b1 && fifo_rd_en === 1'b1 && fq.size() > 0) begin
      fifo_data  <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Reference occupancy: a word arrives one cycle after its read, leaves on handshake.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_occ  <= 0;
      m_infl <= 0;
      m_wc   <= 0;
    end else begin
      cyc    <= cyc + 1;
      m_occ  <= m_occ + m_infl - ((out_valid && out_ready) ? 1 : 0);
      m_infl <= fifo_rd_en ? 1 : 0;
      if (out_valid && out_ready) m_wc <= m_wc + 1;
      if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    check_val("rd_cs_eq_en", fifo_rd_cs, fifo_rd_en);
    if (fifo_empty) check_val("rd_while_empty", fifo_rd_en, 0);
    check_val("valid_vs_occ", out_valid, (m_occ != 0) ? 1 : 0);
    check_val("occ_le_2", (m_occ <= 2) ? 1 : 0, 1);
    if (!rst) begin
      prev_stall = 1'b0;
      check_val("rst_rd_en", fifo_rd_en, 0);
    end else begin
      check_val("wc_running", word_count, m_wc[15:0]);
      if (prev_stall) begin
        check_val("stall_valid", out_valid, 1);
        check_val("stall_data", out_data, prev_data);
        check_val("stall_last", out_last, prev_last);
      end
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (out_valid && first_val < 0) first_val = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_data", out_data, e[7:0]);
          check_val("sb_last", out_last, e[8]);
        end
        last_pop = cyc;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic wait_drain(input int maxc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid && fifo_empty && m_infl == 0) begin
        done = 1'b1;
        break;
      end
    end
    check_val("drain_timeout", done, 1);
  endtask

  initial begin
    int p0;
    logic reached;
    rst = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with a loaded FIFO
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rd_en_held", fifo_rd_en, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_wc", word_count, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_last", out_last, 0);

    // Streaming
    first_rd = -1;
    first_val = -1;
    rst = 1'b1;
    wait_drain(60);
    check_val("stream_latency", first_val - first_rd, 2);
    check_val("stream_back2back", last_pop - first_val, 7);
    check_val("stream_wc", word_count, 8);

    // Back-pressure: out_ready toggles every 3 cycles
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
      if ((i % 3) == 2) out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_drain(60);
    check_val("bp_wc", word_count, 16);

    // Enable drop after two reads
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h20 + i));
    p0 = rd_pulses;
    enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_val("en_reads", rd_pulses - p0, 2);
    check_val("en_fifo_left", fq.size(), 6);
    check_val("en_wc", word_count, 18);
    check_val("en_idle_valid", out_valid, 0);
    enable = 1'b1;
    wait_drain(60);
    check_val("en_resume_wc", word_count, 24);

    // Single word
    p0 = rd_pulses;
    push_word(8'hA5);
    wait_drain(30);
    check_val("single_reads", rd_pulses - p0, 1);
    check_val("single_wc", word_count, 25);
    check_val("single_valid_low", out_valid, 0);

    // Reset with a full skid buffer
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (m_occ == 2) begin
        reached = 1'b1;
        break;
      end
    end
    check_val("mid_occ2_reached", reached, 1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_data", out_data, 0);
    check_val("mid_rst_last", out_last, 0);
    check_val("mid_rst_wc", word_count, 0);
    check_val("mid_rst_rd_en", fifo_rd_en, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(8'(8'h30 + i));
    out_ready = 1'b1;
    wait_drain(60);
    check_val("post_rst_wc", word_count, 5);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
